rv32_single_cycle_datapath: RTL and testbench

- Single-cycle RV32I-subset datapath: PC, 32x32 register file, immediate generator, ALU, branch compare, writeback mux and internal decoder.
- Fetches from an external synchronous program ROM, which is read on the same clock edge that updates the PC.
- Issues word loads and stores to an external data memory.
- Sits between the program ROM and the data memory in the microprocessor top level.

---
 rtl/rv32_single_cycle_datapath.sv | 94 +++++++++
 tb/tb_rv32_single_cycle_datapath.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rv32_single_cycle_datapath.sv
// rv32_single_cycle_datapath: single-cycle RV32I-subset core fed by a synchronous program ROM.
module rv32_single_cycle_datapath #(
    parameter int          PROG_AW  = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic [31:0]        read_data,
    output logic               we,
    output logic [31:0]        addrs,
    output logic [31:0]        data_out,
    output logic [PROG_AW-1:0] prog_addrs,
    output logic [1:0]         pc_ctrl,
    output logic [31:0]        imm
);
    logic [31:0] pc, next_pc, rs1_v, rs2_v, a, b, alu, wd;
    logic [31:0] rf [32];
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, ra1, ra2, sh;
    logic        alt, is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    logic        take, sub, rf_we;
    assign op  = instruction[6:0];
    assign rd  = instruction[11:7];
    assign f3  = instruction[14:12];
    assign ra1 = instruction[19:15];
    assign ra2 = instruction[24:20];
    assign f7  = instruction[31:25];
    assign alt = f7 == 7'b0100000;
    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign is_jal   = op == 7'b1101111;
    assign is_jalr  = op == 7'b1100111 && f3 == 3'b000;
    assign is_br    = op == 7'b1100011 && !f3[1];
    assign is_ld    = op == 7'b0000011 && f3 == 3'b010;
    assign is_st    = op == 7'b0100011 && f3 == 3'b010;
    assign is_opi   = op == 7'b0010011 && (f3 == 3'b001 ? f7 == 7'b0 :
                                           f3 == 3'b101 ? (f7 == 7'b0 || alt) : f3 != 3'b011);
    assign is_op    = op == 7'b0110011 && ((f7 == 7'b0 && f3 != 3'b011) ||
                                           (alt && (f3 == 3'b000 || f3 == 3'b101)));
    // Format chosen from the opcode alone so imm is defined even for bad funct fields
    always_comb begin
        imm = 32'd0;
        if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111)
            imm = {{20{instruction[31]}}, instruction[31:20]};
        else if (op == 7'b0100011)
            imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        else if (op == 7'b1100011)
            imm = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
        else if (is_lui || is_auipc)
            imm = {instruction[31:12], 12'd0};
        else if (is_jal)
            imm = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
    end
    assign rs1_v = ra1 == 5'd0 ? 32'd0 : rf[ra1];
    assign rs2_v = ra2 == 5'd0 ? 32'd0 : rf[ra2];
    assign a   = (is_auipc || is_jal) ? pc : is_lui ? 32'd0 : rs1_v;
    assign b   = (is_op || is_br) ? rs2_v : imm;
    assign sh  = b[4:0];
    assign sub = (is_op && alt && f3 == 3'b000) || ((is_op || is_opi) && alt && f3 == 3'b101);
    always_comb begin
        alu = a + b;
        if (is_op || is_opi)
            alu = f3 == 3'b001 ? a << sh :
                  f3 == 3'b010 ? {31'd0, $signed(a) < $signed(b)} :
                  f3 == 3'b100 ? a ^ b :
                  f3 == 3'b110 ? a | b :
                  f3 == 3'b111 ? a & b :
                  f3 == 3'b101 ? (sub ? 32'($signed(a) >>> sh) : a >> sh) :
                  (sub ? a - b : a + b);
    end
    assign take = f3[2] ? (($signed(rs1_v) < $signed(rs2_v)) ^ f3[0]) : ((rs1_v == rs2_v) ^ f3[0]);
    assign pc_ctrl = rst ? 2'b00 : (is_jal || (is_br && take)) ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
    // Targets are word-aligned here so the PC never holds a misaligned value
    assign next_pc = rst ? RESET_PC :
                     pc_ctrl == 2'b01 ? pc + {imm[31:2], 2'b00} :
                     pc_ctrl == 2'b10 ? {alu[31:2], 2'b00} : pc + 32'd4;
    assign prog_addrs = next_pc[PROG_AW+1:2];
    assign addrs    = alu;
    assign data_out = rs2_v;
    assign we       = is_st && !rst;
    assign wd    = is_ld ? read_data : (is_jal || is_jalr) ? pc + 32'd4 : alu;
    assign rf_we = !rst && rd != 5'd0 && (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op);
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (rf_we) rf[rd] <= wd;
        end
    end
endmodule

// File: tb/tb_rv32_single_cycle_datapath.sv
// tb_rv32_single_cycle_datapath: directed program walk checking bus outputs, PC select and register effects.
module tb_rv32_single_cycle_datapath;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, read_data, addrs, data_out, imm;
    logic        we;
    logic [8:0]  prog_addrs;
    logic [1:0]  pc_ctrl;
    int checks = 0;
    int errors = 0;

    rv32_single_cycle_datapath #(.PROG_AW(9), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .read_data(read_data),
        .we(we), .addrs(addrs), .data_out(data_out), .prog_addrs(prog_addrs),
        .pc_ctrl(pc_ctrl), .imm(imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [31:0] i, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {i[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] i, input logic [4:0] rs2, input logic [4:0] rs1);
        return {i[11:5], rs2, rs1, 3'b010, i[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] i, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] i, input logic [4:0] rd);
        return {i[20], i[10:1], i[11], i[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rd_data);
        instruction = ins;
        read_data   = rd_data;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(enc_s(32'd8, 5'd3, 5'd5), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("rst_we", 32'(we), 32'd0);
            chk("rst_prog_addrs", 32'(prog_addrs), 32'd0);
            chk("rst_pc_ctrl", 32'(pc_ctrl), 32'd0);
            tick();
        end
        rst = 1'b0;
        drive(enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0);
        chk("addi_x1_addrs", addrs, 32'd5);
        chk("addi_x1_prog_addrs", 32'(prog_addrs), 32'd1);
        tick();
        drive(enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'd0);
        chk("addi_x2_imm", imm, 32'hFFFF_FFFD);
        chk("addi_x2_addrs", addrs, 32'hFFFF_FFFD);
        chk("addi_x2_prog_addrs", 32'(prog_addrs), 32'd2);
        tick();
        drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0);
        chk("add_addrs", addrs, 32'd2);
        chk("add_imm", imm, 32'd0);
        chk("add_prog_addrs", 32'(prog_addrs), 32'd3);
        tick();
        drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'd0);
        chk("sub_addrs", addrs, 32'd8);
        tick();
        drive(enc_i(32'h40, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'd0);
        chk("addi_x5_addrs", addrs, 32'h40);
        tick();
        drive(enc_s(32'd8, 5'd3, 5'd5), 32'd0);
        chk("sw_addrs", addrs, 32'h48);
        chk("sw_data_out", data_out, 32'd2);
        chk("sw_we", 32'(we), 32'd1);
        chk("sw_imm", imm, 32'd8);
        tick();
        drive(enc_i(32'd8, 5'd5, 3'b010, 5'd6, 7'b0000011), 32'h1234_5678);
        chk("lw_we", 32'(we), 32'd0);
        chk("lw_addrs", addrs, 32'h48);
        tick();
        drive(enc_s(32'd0, 5'd6, 5'd4), 32'd0);
        chk("sw2_x4_addrs", addrs, 32'd8);
        chk("sw2_x6_data", data_out, 32'h1234_5678);
        chk("sw2_prog_addrs", 32'(prog_addrs), 32'd8);
        tick();
        drive(enc_j(32'd16, 5'd7), 32'd0);
        chk("jal_pc_ctrl", 32'(pc_ctrl), 32'd1);
        chk("jal_imm", imm, 32'd16);
        chk("jal_prog_addrs", 32'(prog_addrs), 32'd12);
        tick();
        drive(enc_i(32'd0, 5'd7, 3'b000, 5'd0, 7'b1100111), 32'd0);
        chk("jalr_pc_ctrl", 32'(pc_ctrl), 32'd2);
        chk("jalr_x7_addrs", addrs, 32'h24);
        chk("jalr_prog_addrs", 32'(prog_addrs), 32'd9);
        tick();
        drive(enc_b(32'd8, 5'd1, 5'd1, 3'b000), 32'd0);
        chk("beq_pc_ctrl", 32'(pc_ctrl), 32'd1);
        chk("beq_prog_addrs", 32'(prog_addrs), 32'd11);
        tick();
        drive(enc_b(32'd8, 5'd1, 5'd1, 3'b001), 32'd0);
        chk("bne_pc_ctrl", 32'(pc_ctrl), 32'd0);
        chk("bne_prog_addrs", 32'(prog_addrs), 32'd12);
        tick();
        drive(enc_i(32'd9, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'd0);
        chk("addi_x0_addrs", addrs, 32'd9);
        tick();
        drive(enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd9), 32'd0);
        chk("x0_zero_addrs", addrs, 32'd0);
        chk("x0_zero_data", data_out, 32'd0);
        chk("x0_prog_addrs", 32'(prog_addrs), 32'd14);
        tick();
        drive(enc_b(32'd8, 5'd1, 5'd2, 3'b100), 32'd0);
        chk("blt_signed_pc_ctrl", 32'(pc_ctrl), 32'd1);
        chk("blt_prog_addrs", 32'(prog_addrs), 32'd16);
        tick();
        drive({20'h12345, 5'd10, 7'b0110111}, 32'd0);
        chk("lui_imm", imm, 32'h1234_5000);
        tick();
        drive(enc_r(7'b0, 5'd1, 5'd2, 3'b010, 5'd11), 32'd0);
        chk("slt_addrs", addrs, 32'd1);
        tick();
        drive(enc_i(32'h401, 5'd2, 3'b101, 5'd12, 7'b0010011), 32'd0);
        chk("srai_addrs", addrs, 32'hFFFF_FFFE);
        tick();
        drive(32'hFFFF_FFFF, 32'd0);
        chk("bad_op_we", 32'(we), 32'd0);
        chk("bad_op_pc_ctrl", 32'(pc_ctrl), 32'd0);
        chk("bad_op_prog_addrs", 32'(prog_addrs), 32'd20);
        tick();
        rst = 1'b1;
        drive(enc_i(32'd7, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0);
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_prog_addrs", 32'(prog_addrs), 32'd0);
        tick();
        rst = 1'b0;
        drive(enc_r(7'b0, 5'd0, 5'd1, 3'b000, 5'd0), 32'd0);
        chk("midrst_x1_cleared", addrs, 32'd0);
        chk("midrst_prog_addrs_after", 32'(prog_addrs), 32'd1);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
